fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_entry_buf.sv | 58 +++++
 rtl/fetch_queue.sv | 131 +++++++++++++
 tb/tb_fetch_queue.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-queue types: FSM states and buffer entry layout (FAULT state only with FETCH_ALIGN_CHECK_EN).
// Entry fields are sized for the widest supported ADDR_W and sliced by the users.
package fetch_pkg;

  localparam int FQ_MAX_W = 32;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {BOOT, RUN, FAULT} fq_state_e;
`else
  typedef enum logic [1:0] {BOOT, RUN} fq_state_e;
`endif

  typedef struct packed {
    logic [FQ_MAX_W-1:0] pc;
    logic [FQ_MAX_W-1:0] instr;
    logic                filled;
  } fq_entry_t;

endpackage

// File: rtl/fetch_entry_buf.sv
// Instruction buffer storage with alloc/fill/read pointers; head entry is visible combinationally.
// No backpressure of its own: the owner guarantees alloc only when a slot is free and fill only for pending entries.
module fetch_entry_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_flush,
  input  logic              i_alloc,
  input  logic [ADDR_W-1:0] i_alloc_pc,
  input  logic              i_alloc_filled,
  input  logic              i_fill,
  input  logic [ADDR_W-1:0] i_fill_data,
  input  logic              i_pop,
  output fq_entry_t         o_head
);

  localparam int PTR_W = $clog2(DEPTH);

  fq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_alloc_ptr;
  logic [PTR_W-1:0] r_fill_ptr;
  logic [PTR_W-1:0] r_rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_rd_ptr    <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_rd_ptr    <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i].filled <= 1'b0;
    end else begin
      // A pre-filled (fault) entry is always the last allocation before a flush, so fill never reaches it.
      if (i_alloc) begin
        r_mem[r_alloc_ptr].pc     <= FQ_MAX_W'(i_alloc_pc);
        r_mem[r_alloc_ptr].instr  <= '0;
        r_mem[r_alloc_ptr].filled <= i_alloc_filled;
        r_alloc_ptr               <= r_alloc_ptr + PTR_W'(1);
      end
      if (i_fill) begin
        r_mem[r_fill_ptr].instr  <= FQ_MAX_W'(i_fill_data);
        r_mem[r_fill_ptr].filled <= 1'b1;
        r_fill_ptr               <= r_fill_ptr + PTR_W'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  assign o_head = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: issues aligned imem requests while credits allow, buffers in-order responses, feeds decode (0-cycle head visibility).
// Branch flush drops in-flight responses via drop_cnt; FETCH_ALIGN_CHECK_EN adds misaligned-PC FAULT handling and id_fault.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] next_address,
  output logic              pc_freeze,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [ADDR_W-1:0] imem_rsp_data,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  input  logic              id_ready
`ifdef FETCH_ALIGN_CHECK_EN
  ,output logic             id_fault
`endif
);

  localparam int              CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  fq_state_e        r_state;
  logic [CNT_W-1:0] r_alloc_cnt;
  logic [CNT_W-1:0] r_pend_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_flush;
  logic             w_run;
  logic [CNT_W:0]   w_credit_sum;
  logic             w_credit_ok;
  logic             w_req_hs;
  logic             w_fault_alloc;
  logic             w_alloc;
  logic             w_fill;
  logic             w_pop;
  fq_entry_t        w_head;

  assign w_flush      = branch_taken && (r_state != BOOT);
  assign w_run        = (r_state == RUN);
  // Responses still owed to flushed entries occupy credits until they drain.
  assign w_credit_sum = {1'b0, r_alloc_cnt} + {1'b0, r_drop_cnt};
  assign w_credit_ok  = w_credit_sum < {1'b0, DEPTH_CNT};

`ifdef FETCH_ALIGN_CHECK_EN
  logic w_misalign;
  assign w_misalign     = |pc[1:0];
  assign w_fault_alloc  = w_run && !branch_taken && w_misalign && (r_alloc_cnt < DEPTH_CNT);
  assign imem_req_valid = w_run && !branch_taken && !w_misalign && w_credit_ok;
  // Only fault entries can hold a misaligned pc.
  assign id_fault       = id_valid && (|id_pc[1:0]);
`else
  assign w_fault_alloc  = 1'b0;
  assign imem_req_valid = w_run && !branch_taken && w_credit_ok;
`endif

  assign imem_req_addr = (r_state == BOOT) ? '0 : {pc[ADDR_W-1:2], 2'b00};
  assign w_req_hs      = imem_req_valid && imem_req_ready;
  assign w_alloc       = w_req_hs || w_fault_alloc;
  assign w_fill        = imem_rsp_valid && (r_drop_cnt == '0) && !w_flush;
  assign w_pop         = id_valid && id_ready;

  assign id_valid = (r_alloc_cnt != '0) && w_head.filled;
  assign id_pc    = id_valid ? w_head.pc[ADDR_W-1:0]    : '0;
  assign id_instr = id_valid ? w_head.instr[ADDR_W-1:0] : '0;

  always_comb begin
    next_address = pc;
    pc_freeze    = 1'b1;
    if (w_flush) begin
      next_address = branch_target;
      pc_freeze    = 1'b0;
    end else if (w_req_hs) begin
      next_address = pc + ADDR_W'(4);
      pc_freeze    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= BOOT;
      r_alloc_cnt <= '0;
      r_pend_cnt  <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (r_state == BOOT) r_state <= RUN;
`ifdef FETCH_ALIGN_CHECK_EN
      else if (r_state == FAULT && w_flush) r_state <= RUN;
      else if (w_fault_alloc) r_state <= FAULT;
`endif

      if (w_flush) begin
        r_alloc_cnt <= '0;
        r_pend_cnt  <= '0;
        // A response landing in the flush cycle already pays off one of the newly owed responses.
        r_drop_cnt  <= r_drop_cnt + r_pend_cnt - CNT_W'(imem_rsp_valid);
      end else begin
        r_alloc_cnt <= r_alloc_cnt + CNT_W'(w_alloc) - CNT_W'(w_pop);
        r_pend_cnt  <= r_pend_cnt + CNT_W'(w_req_hs) - CNT_W'(w_fill);
        if (imem_rsp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CNT_W'(1);
      end
    end
  end

  fetch_entry_buf #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk            (clk),
    .reset          (reset),
    .i_flush        (w_flush),
    .i_alloc        (w_alloc),
    .i_alloc_pc     (pc),
    .i_alloc_filled (w_fault_alloc),
    .i_fill         (w_fill),
    .i_fill_data    (imem_rsp_data),
    .i_pop          (w_pop),
    .o_head         (w_head)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: PC register and in-order instruction memory modelled here.
module tb_fetch_queue;

  localparam logic [31:0] KEY = 32'h1357_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] next_address;
  logic        pc_freeze;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        id_fault;
`endif

  fetch_queue #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .next_address   (next_address),
    .pc_freeze      (pc_freeze),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_ready       (id_ready)
`ifdef FETCH_ALIGN_CHECK_EN
    ,.id_fault      (id_fault)
`endif
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          lat    = 2;
  logic [31:0] mq_addr [$];
  int          mq_due  [$];

  typedef struct {
    logic        id_rdy;
    logic        v;
    logic [31:0] addr;
    logic        frz;
    logic [31:0] nxt;
    logic        idv;
    logic [31:0] idpc;
  } vec_t;

  vec_t tbl [13];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: capture pre-edge handshakes, then advance PC register and memory model.
  task automatic step();
    logic        hs;
    logic [31:0] hs_addr;
    logic [31:0] nxt;
    hs      = imem_req_valid & imem_req_ready;
    hs_addr = imem_req_addr;
    nxt     = next_address;
    @(posedge clk);
    cyc++;
    #1;
    pc = nxt;
    if (hs) begin
      mq_addr.push_back(hs_addr);
      mq_due.push_back(cyc + lat - 1);
    end
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    reset          = 1'b0;
    branch_taken   = 1'b0;
    branch_target  = '0;
    id_ready       = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    pc             = start_pc;
    mq_addr.delete();
    mq_due.delete();
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_id_valid", id_valid, 1'b0);
    chk1("rst_pc_freeze", pc_freeze, 1'b1);
    chk("rst_next_address", next_address, start_pc);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    reset = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    logic found;
    int   nreq;

    //            id_rdy v     addr          frz   next          idv   id_pc
    tbl[0]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0004, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0000_0008, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 32'h0000_0008, 1'b0, 32'h0000_000C, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0000_0010, 1'b1, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_0014, 1'b1, 32'h4};
    tbl[6]  = '{1'b1, 1'b1, 32'h0000_0014, 1'b0, 32'h0000_0018, 1'b1, 32'h8};
    tbl[7]  = '{1'b1, 1'b1, 32'h0000_0018, 1'b0, 32'h0000_001C, 1'b1, 32'hC};
    tbl[8]  = '{1'b0, 1'b1, 32'h0000_001C, 1'b0, 32'h0000_0020, 1'b1, 32'h10};
    tbl[9]  = '{1'b0, 1'b0, 32'h0000_0020, 1'b1, 32'h0000_0020, 1'b1, 32'h10};
    tbl[10] = '{1'b0, 1'b0, 32'h0000_0020, 1'b1, 32'h0000_0020, 1'b1, 32'h10};
    tbl[11] = '{1'b1, 1'b0, 32'h0000_0020, 1'b1, 32'h0000_0020, 1'b1, 32'h10};
    tbl[12] = '{1'b1, 1'b1, 32'h0000_0020, 1'b0, 32'h0000_0024, 1'b1, 32'h14};

    // Streaming from pc=0 with latency-2 memory, then decode stall filling the buffer.
    lat = 2;
    do_reset(32'h0);
    imem_req_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      id_ready = tbl[i].id_rdy;
      #1;
      chk1($sformatf("t%0d_req_valid", i), imem_req_valid, tbl[i].v);
      if (tbl[i].v) chk($sformatf("t%0d_req_addr", i), imem_req_addr, tbl[i].addr);
      chk1($sformatf("t%0d_pc_freeze", i), pc_freeze, tbl[i].frz);
      chk($sformatf("t%0d_next_address", i), next_address, tbl[i].nxt);
      chk1($sformatf("t%0d_id_valid", i), id_valid, tbl[i].idv);
      if (tbl[i].idv) begin
        chk($sformatf("t%0d_id_pc", i), id_pc, tbl[i].idpc);
        chk($sformatf("t%0d_id_instr", i), id_instr, mem_data(tbl[i].idpc));
      end
      step();
    end

    // Decode never ready: exactly DEPTH requests, then hold until one pop.
    do_reset(32'h0);
    imem_req_ready = 1'b1;
    id_ready       = 1'b0;
    nreq           = 0;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (imem_req_valid && imem_req_ready) nreq++;
      step();
      #1;
    end
    chk("full_req_count", 32'(nreq), 32'd4);
    chk1("full_req_valid", imem_req_valid, 1'b0);
    chk1("full_pc_freeze", pc_freeze, 1'b1);
    chk("full_next_address", next_address, 32'h10);
    chk1("full_id_valid", id_valid, 1'b1);
    id_ready = 1'b1;
    #1;
    step();
    id_ready = 1'b0;
    #1;
    chk1("after_pop_req_valid", imem_req_valid, 1'b1);
    chk("after_pop_req_addr", imem_req_addr, 32'h10);

    // Three requests in flight when a branch flushes; their responses must be dropped.
    lat = 6;
    do_reset(32'h0);
    imem_req_ready = 1'b1;
    #1;
    repeat (4) begin step(); #1; end
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    #1;
    chk("flush_next_address", next_address, 32'h100);
    chk1("flush_pc_freeze", pc_freeze, 1'b0);
    chk1("flush_req_valid", imem_req_valid, 1'b0);
    chk1("flush_id_valid", id_valid, 1'b0);
    step();
    branch_taken = 1'b0;
    #1;
    chk1("redirect_req_valid", imem_req_valid, 1'b1);
    chk("redirect_req_addr", imem_req_addr, 32'h100);
    step();
    #1;
    chk1("drop_credit_block", imem_req_valid, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      #1;
      if (id_valid) found = 1'b1;
    end
    chk1("flush_first_id_found", found, 1'b1);
    chk("flush_first_id_pc", id_pc, 32'h100);
    chk("flush_first_id_instr", id_instr, mem_data(32'h100));
    chk("flush_first_id_cycle", 32'(cyc), 32'd12);

    // Branch in the same cycle as a response and a pop.
    lat = 2;
    do_reset(32'h0);
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    #1;
    repeat (4) begin step(); #1; end
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    #1;
    chk1("coinc_id_valid", id_valid, 1'b1);
    chk("coinc_id_pc", id_pc, 32'h0);
    chk("coinc_next_address", next_address, 32'h200);
    step();
    branch_taken = 1'b0;
    #1;
    chk1("coinc_no_stale", id_valid, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      #1;
      if (id_valid) found = 1'b1;
    end
    chk1("coinc_id_found", found, 1'b1);
    chk("coinc_first_id_pc", id_pc, 32'h200);
    chk("coinc_first_id_instr", id_instr, mem_data(32'h200));
    chk("coinc_first_id_cycle", 32'(cyc), 32'd8);

    // PC wrap; the reset here lands mid-transaction.
    do_reset(32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    #1;
    step();
    #1;
    chk1("wrap_req_valid", imem_req_valid, 1'b1);
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    chk("wrap_next_address", next_address, 32'h0);
    chk1("wrap_pc_freeze", pc_freeze, 1'b0);
    step();
    #1;
    chk("wrap_req_addr2", imem_req_addr, 32'h0);

`ifdef FETCH_ALIGN_CHECK_EN
    do_reset(32'h6);
    imem_req_ready = 1'b1;
    #1;
    step();
    #1;
    chk1("mis_req_valid", imem_req_valid, 1'b0);
    chk1("mis_pc_freeze", pc_freeze, 1'b1);
    chk("mis_next_address", next_address, 32'h6);
    step();
    #1;
    chk1("mis_id_valid", id_valid, 1'b1);
    chk1("mis_id_fault", id_fault, 1'b1);
    chk("mis_id_pc", id_pc, 32'h6);
    chk("mis_id_instr", id_instr, 32'h0);
    repeat (3) begin
      step();
      #1;
      chk1("fault_req_valid", imem_req_valid, 1'b0);
      chk1("fault_pc_freeze", pc_freeze, 1'b1);
    end
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    #1;
    chk("fault_exit_next", next_address, 32'h40);
    chk1("fault_exit_freeze", pc_freeze, 1'b0);
    step();
    branch_taken = 1'b0;
    #1;
    chk1("rerun_req_valid", imem_req_valid, 1'b1);
    chk("rerun_req_addr", imem_req_addr, 32'h40);
    chk1("rerun_id_valid", id_valid, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
